ingress_rdreq_dispatch: RTL and testbench

Parametrised read-request dispatcher on the ingress path, downstream of the TLP pre-parser.
- Decodes each memory-read TLP's DW address into a {register, action, channel} destination.
- Captures the completion context (requester ID, tag, lower address) and queues both in a small FIFO.
- Presents entries to the action/register modules over a valid/ready handshake.
- Limits outstanding reads until the egress completion builder reports completions done.

---
 rtl/pcie_rdreq_pkg.sv | 55 +++++
 rtl/rdreq_ctx_fifo.sv | 58 +++++
 rtl/ingress_rdreq_dispatch.sv | 150 +++++++++++++++
 tb/tb_ingress_rdreq_dispatch.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_rdreq_pkg.sv
// Shared types and encodings for the ingress read-request dispatcher.
package pcie_rdreq_pkg;

   localparam int PCIE_DATA_WIDTH = 256;
   localparam int PCIE_DATA_KW    = PCIE_DATA_WIDTH / 32;

   typedef struct packed {
      logic [63:0] addr;
      logic [9:0]  length;
      logic [15:0] requester_id;
      logic [7:0]  tag;
      logic [2:0]  tc;
      logic [1:0]  attr;
   } tlp_head_t;

   typedef struct packed {
      logic [15:0] requester_id;
      logic [7:0]  tag;
      logic [6:0]  lower_addr;
      logic [2:0]  tc;
      logic [1:0]  attr;
   } rdreq_ctx_t;

   // DW offset within a channel's 64-byte register window (addr[5:2])
   localparam logic [3:0] OFS_TX_LEN  = 4'b1000;
   localparam logic [3:0] OFS_TX_ADDR = 4'b1001;
   localparam logic [3:0] OFS_TX_CTRL = 4'b1110;
   localparam logic [3:0] OFS_RX_CTRL = 4'b1101;
   localparam logic [3:0] OFS_GLB_0   = 4'b1010;
   localparam logic [3:0] OFS_GLB_1   = 4'b1011;
   localparam logic [3:0] OFS_GLB_2   = 4'b1100;
   localparam logic [3:0] OFS_GLB_3   = 4'b1111;

   localparam logic [1:0] ACT_TX   = 2'b00;
   localparam logic [1:0] ACT_RX   = 2'b01;
   localparam logic [1:0] ACT_GLB  = 2'b10;
   localparam logic [1:0] ACT_NONE = 2'b11;

   localparam logic [2:0] REG_0    = 3'b000;
   localparam logic [2:0] REG_1    = 3'b001;
   localparam logic [2:0] REG_2    = 3'b010;
   localparam logic [2:0] REG_3    = 3'b011;
   localparam logic [2:0] REG_NONE = 3'b111;

   function automatic rdreq_ctx_t ctx_from_head(input tlp_head_t h);
      rdreq_ctx_t c;
      c.requester_id = h.requester_id;
      c.tag          = h.tag;
      c.lower_addr   = {h.addr[6:2], 2'b00};
      c.tc           = h.tc;
      c.attr         = h.attr;
      return c;
   endfunction

endpackage

// File: rtl/rdreq_ctx_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; head entry read from registered storage.
// Latency: push visible at the head the next cycle; push ignored when full, pop ignored when empty.
module rdreq_ctx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_dat_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is reset so the head outputs read as zero straight out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
      end
   end

endmodule

// File: rtl/ingress_rdreq_dispatch.sv
// Decodes memory-read TLPs into {reg,action,channel} + completion context, queues and dispatches them; optional RDREQ_UNMAPPED_CNT_EN counter.
// Latency: accept to rd_valid 1 cycle min; rdreq_rdy drops when the FIFO is full or MAX_OUTSTANDING reads await cpl_done.
module ingress_rdreq_dispatch
   import pcie_rdreq_pkg::*;
#(
   parameter int CHANNEL_NUM     = 12,
   parameter int CH_W            = 4,
   parameter int FIFO_DEPTH      = 4,
   parameter int MAX_OUTSTANDING = 8,
   parameter int TDEST_W         = CH_W + 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [PCIE_DATA_WIDTH-1:0] rdreq_data,
   input  logic [PCIE_DATA_KW-1:0]    rdreq_keep,
   input  tlp_head_t                  rdreq_meta,
   input  logic                       rdreq_valid,
   output logic                       rdreq_rdy,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [TDEST_W-1:0]         rd_tdest,
   output rdreq_ctx_t                 rd_ctx,
   output logic                       rd_err,
   input  logic                       cpl_done,
   output logic [7:0]                 outstanding
`ifdef RDREQ_UNMAPPED_CNT_EN
   ,
   output logic [15:0]                unmapped_cnt
`endif
);

   localparam int             ENTRY_W  = 1 + TDEST_W + $bits(rdreq_ctx_t);
   localparam logic [CH_W:0]  CH_LIMIT = (CH_W + 1)'(CHANNEL_NUM);
   localparam logic [7:0]     MAX_OUT  = 8'(MAX_OUTSTANDING);

   logic [3:0]         ofs;
   logic [CH_W-1:0]    ch;
   logic [2:0]         dec_reg;
   logic [1:0]         dec_act;
   logic               chan_path;
   logic               unmapped;
   logic [CH_W-1:0]    dec_ch;
   logic               dec_err;
   logic [TDEST_W-1:0] dec_tdest;

   logic               accept;
   logic               cpl_dec;
   logic               rdy_en_q;
   logic [7:0]         outstanding_q, outstanding_d;

   logic [ENTRY_W-1:0] push_dat;
   logic [ENTRY_W-1:0] pop_dat;
   logic               fifo_full;
   logic               fifo_empty;
   logic               unused_ok;

   assign unused_ok = ^{rdreq_data, rdreq_keep, rdreq_meta};

   assign ofs = rdreq_meta.addr[5:2];
   assign ch  = rdreq_meta.addr[6 +: CH_W];

   always_comb begin
      dec_reg   = REG_NONE;
      dec_act   = ACT_NONE;
      chan_path = 1'b0;
      unmapped  = 1'b0;
      case (ofs)
         OFS_TX_LEN:  begin dec_reg = REG_0; dec_act = ACT_TX;  chan_path = 1'b1; end
         OFS_TX_ADDR: begin dec_reg = REG_1; dec_act = ACT_TX;  chan_path = 1'b1; end
         OFS_TX_CTRL: begin dec_reg = REG_2; dec_act = ACT_TX;  chan_path = 1'b1; end
         OFS_RX_CTRL: begin dec_reg = REG_2; dec_act = ACT_RX;  chan_path = 1'b1; end
         OFS_GLB_0:   begin dec_reg = REG_0; dec_act = ACT_GLB; end
         OFS_GLB_1:   begin dec_reg = REG_1; dec_act = ACT_GLB; end
         OFS_GLB_2:   begin dec_reg = REG_2; dec_act = ACT_GLB; end
         OFS_GLB_3:   begin dec_reg = REG_3; dec_act = ACT_GLB; end
         default:     unmapped = 1'b1;
      endcase
   end

   // Only per-channel registers carry a channel; global and unmapped hits report channel 0
   assign dec_ch    = chan_path ? ch : '0;
   assign dec_err   = unmapped
                    || (chan_path && ({1'b0, ch} >= CH_LIMIT))
                    || (rdreq_meta.length != 10'd1);
   assign dec_tdest = {dec_reg, dec_act, dec_ch};

   // rdy_en_q keeps rdreq_rdy low for the whole reset and releases it one clock later
   assign rdreq_rdy = rdy_en_q && !fifo_full && (outstanding_q < MAX_OUT);
   assign accept    = rdreq_valid && rdreq_rdy;
   assign cpl_dec   = cpl_done && (outstanding_q != 8'd0);

   assign push_dat = {dec_err, dec_tdest, ctx_from_head(rdreq_meta)};

   rdreq_ctx_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (accept),
      .push_dat_i (push_dat),
      .pop_i      (rd_valid && rd_ready),
      .pop_dat_o  (pop_dat),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   assign rd_valid                   = !fifo_empty;
   assign {rd_err, rd_tdest, rd_ctx} = pop_dat;

   always_comb begin
      outstanding_d = outstanding_q;
      case ({accept, cpl_dec})
         2'b10:   outstanding_d = outstanding_q + 8'd1;
         2'b01:   outstanding_d = outstanding_q - 8'd1;
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en_q      <= 1'b0;
         outstanding_q <= '0;
      end else begin
         rdy_en_q      <= 1'b1;
         outstanding_q <= outstanding_d;
      end
   end

   assign outstanding = outstanding_q;

`ifdef RDREQ_UNMAPPED_CNT_EN
   logic [15:0] unmapped_cnt_q, unmapped_cnt_d;

   always_comb begin
      unmapped_cnt_d = unmapped_cnt_q;
      if (accept && dec_err && (unmapped_cnt_q != 16'hFFFF)) begin
         unmapped_cnt_d = unmapped_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) unmapped_cnt_q <= '0;
      else        unmapped_cnt_q <= unmapped_cnt_d;
   end

   assign unmapped_cnt = unmapped_cnt_q;
`endif

endmodule

// File: tb/tb_ingress_rdreq_dispatch.sv
// Directed bench: queue-based reference model checked every negedge, plus hand-computed spot checks.
module tb_ingress_rdreq_dispatch;
   import pcie_rdreq_pkg::*;

   localparam int CHN   = 12;
   localparam int DEPTH = 4;
   localparam int MAXO  = 8;
   localparam int TDW   = 9;

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b1;
   logic [PCIE_DATA_WIDTH-1:0] rdreq_data = '0;
   logic [PCIE_DATA_KW-1:0]    rdreq_keep = '0;
   tlp_head_t                  rdreq_meta = '0;
   logic                       rdreq_valid = 1'b0;
   logic                       rdreq_rdy;
   logic                       rd_valid;
   logic                       rd_ready = 1'b1;
   logic [TDW-1:0]             rd_tdest;
   rdreq_ctx_t                 rd_ctx;
   logic                       rd_err;
   logic                       cpl_done = 1'b0;
   logic [7:0]                 outstanding;
`ifdef RDREQ_UNMAPPED_CNT_EN
   logic [15:0]                unmapped_cnt;
`endif

   always #5 clk = ~clk;

   ingress_rdreq_dispatch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rdreq_data  (rdreq_data),
      .rdreq_keep  (rdreq_keep),
      .rdreq_meta  (rdreq_meta),
      .rdreq_valid (rdreq_valid),
      .rdreq_rdy   (rdreq_rdy),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .rd_tdest    (rd_tdest),
      .rd_ctx      (rd_ctx),
      .rd_err      (rd_err),
      .cpl_done    (cpl_done),
      .outstanding (outstanding)
`ifdef RDREQ_UNMAPPED_CNT_EN
      ,
      .unmapped_cnt(unmapped_cnt)
`endif
   );

   typedef struct packed {
      logic           err;
      logic [TDW-1:0] tdest;
      rdreq_ctx_t     ctx;
   } exp_t;

   exp_t mq[$];
   int   m_out = 0;
   bit   m_en = 1'b0;
   int   m_unm = 0;
   int   tests = 0;
   int   fails = 0;
   int   reg_tab[16];
   int   act_tab[16];
   bit   chan_tab[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_rdy();
      return m_en && (mq.size() < DEPTH) && (m_out < MAXO);
   endfunction

   function automatic exp_t model(input tlp_head_t h);
      exp_t e;
      int   o  = int'(h.addr[5:2]);
      int   ch = int'(h.addr[9:6]);
      int   c  = chan_tab[o] ? ch : 0;
      e.err   = (act_tab[o] == 3) || (chan_tab[o] && ch >= CHN) || (h.length != 10'd1);
      e.tdest = TDW'(reg_tab[o] * 64 + act_tab[o] * 16 + c);
      e.ctx.requester_id = h.requester_id;
      e.ctx.tag          = h.tag;
      e.ctx.lower_addr   = h.addr[6:0] & 7'h7C;
      e.ctx.tc           = h.tc;
      e.ctx.attr         = h.attr;
      return e;
   endfunction

   task automatic m_reset();
      mq.delete();
      m_out = 0;
      m_en  = 1'b0;
      m_unm = 0;
   endtask

   task automatic tick();
      bit   acc;
      bit   pop;
      bit   dec;
      exp_t e;
      acc = rdreq_valid && m_rdy();
      pop = (mq.size() > 0) && rd_ready;
      dec = cpl_done && (m_out > 0);
      e   = model(rdreq_meta);
      @(posedge clk);
      #1;
      if (!rst_n) begin
         m_reset();
         return;
      end
      if (pop) void'(mq.pop_front());
      if (acc) begin
         mq.push_back(e);
         if (e.err && m_unm < 65535) m_unm++;
      end
      m_out = m_out + int'(acc) - int'(dec);
      m_en  = 1'b1;
   endtask

   task automatic send(input logic [63:0] addr, input logic [9:0] len,
                       input logic [7:0] tag, input logic [15:0] rid);
      bit ok = 1'b0;
      rdreq_meta.addr         = addr;
      rdreq_meta.length       = len;
      rdreq_meta.tag          = tag;
      rdreq_meta.requester_id = rid;
      rdreq_meta.tc           = 3'(tag);
      rdreq_meta.attr         = 2'(tag >> 1);
      rdreq_data              = {8{$urandom()}};
      rdreq_valid             = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = m_rdy();
         tick();
      end
      rdreq_valid = 1'b0;
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: tag %0h never accepted, expected acceptance within 20 cycles", tag);
      end
   endtask

   // Every cycle: DUT handshake, counters and head entry against the model
   always @(negedge clk) begin
      check("rdy", rdreq_rdy, m_rdy());
      check("outstanding", outstanding, m_out);
      check("rd_valid", rd_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         check("rd_tdest", rd_tdest, mq[0].tdest);
         check("rd_ctx", rd_ctx, mq[0].ctx);
         check("rd_err", rd_err, mq[0].err);
      end
`ifdef RDREQ_UNMAPPED_CNT_EN
      check("unmapped_cnt", unmapped_cnt, m_unm);
`endif
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         reg_tab[i] = 7; act_tab[i] = 3; chan_tab[i] = 1'b0;
      end
      reg_tab[8]  = 0; act_tab[8]  = 0; chan_tab[8]  = 1'b1;
      reg_tab[9]  = 1; act_tab[9]  = 0; chan_tab[9]  = 1'b1;
      reg_tab[14] = 2; act_tab[14] = 0; chan_tab[14] = 1'b1;
      reg_tab[13] = 2; act_tab[13] = 1; chan_tab[13] = 1'b1;
      reg_tab[10] = 0; act_tab[10] = 2;
      reg_tab[11] = 1; act_tab[11] = 2;
      reg_tab[12] = 2; act_tab[12] = 2;
      reg_tab[15] = 3; act_tab[15] = 2;

      #1 rst_n = 1'b0;
      #1;
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_tdest", rd_tdest, 0);
      check("rst_rd_ctx", rd_ctx, 0);
      check("rst_rd_err", rd_err, 0);
      check("rst_outstanding", outstanding, 0);
      check("rst_rdy", rdreq_rdy, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check("rdy_after_reset", rdreq_rdy, 1);

      // Single TX read: offset 1001, ch 3
      send(64'hE4, 10'd1, 8'h5A, 16'hBEEF);
      check("t1_valid", rd_valid, 1);
      check("t1_tdest", rd_tdest, 9'h043);
      check("t1_tag", rd_ctx.tag, 8'h5A);
      check("t1_rid", rd_ctx.requester_id, 16'hBEEF);
      check("t1_lower_addr", rd_ctx.lower_addr, 7'h64);
      check("t1_err", rd_err, 0);
      check("t1_outstanding", outstanding, 1);
      tick();
      check("t1_drained", rd_valid, 0);

      // Global offset 1111 with ch 7: channel forced to 0
      send(64'h1FC, 10'd1, 8'h11, 16'h0102);
      check("t2_tdest", rd_tdest, 9'h0E0);
      check("t2_err", rd_err, 0);
      tick();

      // Unmapped offset, out-of-range channel, and a 2-DW read
      send(64'h14, 10'd1, 8'h21, 16'h0001);
      check("t3_unmapped_tdest", rd_tdest, 9'h1F0);
      check("t3_unmapped_err", rd_err, 1);
      tick();
      send(64'h360, 10'd1, 8'h22, 16'h0001);
      check("t3_ch13_tdest", rd_tdest, 9'h00D);
      check("t3_ch13_err", rd_err, 1);
      tick();
`ifdef RDREQ_UNMAPPED_CNT_EN
      check("t3_unmapped_cnt", unmapped_cnt, 2);
`endif
      send(64'hE4, 10'd2, 8'h23, 16'h0001);
      check("t3_len_tdest", rd_tdest, 9'h043);
      check("t3_len_err", rd_err, 1);
      tick();
      check("t3_outstanding", outstanding, 5);

      cpl_done = 1'b1;
      repeat (5) tick();
      tick();
      check("cpl_at_zero", outstanding, 0);
      cpl_done = 1'b0;

      // Fill the FIFO with the consumer stalled, then drain in order
      rd_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(64'h2A0 + 64'(i * 4), 10'd1, 8'(i), 16'h0A00);
      check("full_rdy", rdreq_rdy, 0);
      rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_tag", rd_ctx.tag, i);
         tick();
      end
      check("drain_empty", rd_valid, 0);

      // Outstanding limit
      for (int i = 0; i < 4; i++) send(64'h0E4, 10'd1, 8'(16 + i), 16'h0B00);
      tick();
      check("max_out", outstanding, 8);
      check("max_rdy", rdreq_rdy, 0);
      rdreq_meta.tag = 8'h77;
      rdreq_valid    = 1'b1;
      cpl_done       = 1'b1;
      tick();
      check("cpl_at_max_out", outstanding, 7);
      check("cpl_at_max_rdy", rdreq_rdy, 1);
      cpl_done = 1'b0;
      tick();
      check("refill_out", outstanding, 8);
      rdreq_valid = 1'b0;
      cpl_done    = 1'b1;
      tick();
      rdreq_valid = 1'b1;
      tick();
      check("simul_acc_cpl", outstanding, 7);
      rdreq_valid = 1'b0;
      repeat (7) tick();
      cpl_done = 1'b0;
      check("out_cleared", outstanding, 0);

      // Asynchronous reset with entries queued
      rd_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(64'h0E4, 10'd1, 8'(32 + i), 16'h0C00);
      check("pre_rst_out", outstanding, 3);
      #1 rst_n = 1'b0;
      m_reset();
      #1;
      check("async_rd_valid", rd_valid, 0);
      check("async_outstanding", outstanding, 0);
      check("async_rdy", rdreq_rdy, 0);
      repeat (2) tick();
      rst_n    = 1'b1;
      rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_no_dispatch", rd_valid, 0);
      end
`ifdef RDREQ_UNMAPPED_CNT_EN
      check("post_rst_unmapped_cnt", unmapped_cnt, 0);
`endif
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
